adv7513_reg_writer: RTL and testbench
=====================================

# adv7513_reg_writer

Register-write sequencer downstream of the ADV7513 reconfiguration stage. On each `reconf` pulse it snapshots the requested video mode, clock-delay and colorspace settings. It then issues a fixed, ordered list of ADV7513 register writes through a single-outstanding request/acknowledge port to the I2C master. It retries failed writes, restarts cleanly when a new reconfiguration arrives mid-sequence, and reports busy/done/error status to the controller.

## Interface
- `MAX_RETRY`, 3: re-attempts per write after NACK or timeout before abort.
- `ACK_TIMEOUT`, 4095: cycles from request assertion to an implied failure; counter is 12 bits.
- `POWER_ON_RECONF`, 1: 1 = start one sequence automatically after reset release.

Ports:
- `clock`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `reconf`  in  1  one-cycle request to (re)program the ADV7513.
- `vic`  in  6  CEA video identification code.
- `pixel_repeat`  in  2  pixel repetition factor minus one.
- `clock_delay`  in  8  value for register 0xBA.
- `colorspace`  in  2  00 RGB full, 01 RGB limited, 10 YCbCr 4:4:4, 11 reserved (treated as 10).
- `i2c_req`  out  1  write request, held until acknowledged.
- `i2c_reg_addr`  out  8  ADV7513 register address.
- `i2c_reg_data`  out  8  register data.
- `i2c_ack`  in  1  one-cycle completion pulse from the I2C master.
- `i2c_err`  in  1  NACK flag, valid only together with `i2c_ack`.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse when a sequence completes without error.
- `error`  out  1  sticky abort flag, cleared when the next sequence starts.

## Operation
- Write list, index 0..5, with values taken from the snapshot:
  - 0: 0x3C ← {2'b00, vic}
  - 1: 0x3B ← {1'b0, 2'b10, pixel_repeat, pixel_repeat, 1'b0}
  - 2: 0xBA ← clock_delay
  - 3: 0x16 ← {cs_ycc, 7'h30}, where cs_ycc = colorspace[1]
  - 4: 0x18 ← {colorspace==2'b01, 7'h46}
  - 5: 0x55 ← {1'b0, cs_ycc ? 2'b10 : 2'b00, 5'h12}
- States:
  - IDLE: on `reconf`, capture all four inputs into the snapshot, set index = 0 and retry = 0, clear `error`, go to REQ.
  - REQ: drive `i2c_req` = 1 with addr/data for the current index, clear the timeout counter, go to WAIT.
  - WAIT: addr/data remain stable.
    - `i2c_ack` with `!i2c_err`: go to GAP and advance.
    - `i2c_ack` with `i2c_err`, or timeout counter = ACK_TIMEOUT: go to RETRY.
  - RETRY: deassert `i2c_req`. If retry < MAX_RETRY, increment retry and go to REQ. Otherwise set `error`, clear `busy`, go to IDLE.
  - GAP: `i2c_req` low for exactly one cycle. If a restart is pending, load a new snapshot, set index = 0, retry = 0, go to REQ. Else if index = 5, pulse `done` and go to IDLE. Else increment index, set retry = 0, go to REQ.
- `reconf` outside IDLE sets `pending`. `pending` is consumed at the next GAP or RETRY exit; the snapshot is taken at that point.
  - The outstanding write is never abandoned, because the I2C master cannot be cancelled.
  - A RETRY that would abort restarts the sequence instead when `pending` is set; `error` stays clear.
- `i2c_ack` while `i2c_req` = 0 is ignored.
- `busy` = 1 in every state except IDLE.
- Reset (async, any state): all outputs 0, state IDLE, `pending` = POWER_ON_RECONF. A pending flag in IDLE behaves as `reconf`.

## Timing
- Reset values: `i2c_req` 0, `i2c_reg_addr` 0x00, `i2c_reg_data` 0x00, `busy` 0, `done` 0, `error` 0.
- All outputs are registered.
- `reconf` sampled at edge k: `busy` and `i2c_req` go high after edge k+1, with addr = 0x3C.
- `i2c_ack` sampled at edge a: `i2c_req` low after a+1. Next `i2c_req` high after a+2; minimum one low cycle between writes.
- Best case with a zero-wait master is 3 cycles per write. `done` is high for the cycle after the final GAP, with `busy` falling at the same time.
- Timeout: with no ack, RETRY is entered ACK_TIMEOUT+1 cycles after `i2c_req` rises.
- `reconf` coincident with `i2c_ack` in WAIT: the ack completes the current write and `pending` is set. Both take effect.

## Test plan
- Zero-wait ack master; vic = 16, pixel_repeat = 0, clock_delay = 0x60, colorspace = 00 → writes (3C,10) (3B,40) (BA,60) (16,30) (18,46) (55,12) in order, then one `done` pulse. POWER_ON_RECONF = 1 also produces this sequence after reset with no `reconf`.
- colorspace = 01, then 10 → (18,C6), and (16,B0) plus (55,52) respectively. pixel_repeat = 1 → (3B,4A).
- NACK on write 2 twice, then ACK → 0xBA issued 3 times, `error` = 0, `done` = 1. Permanent NACK → 4 attempts, then `error` = 1, `busy` = 0, no `done`.
- No ack, ACK_TIMEOUT = 15 → `i2c_req` high for 16 cycles per attempt, 4 attempts, then `error` = 1.
- `reconf` with vic = 4 during write 3 of a vic = 16 sequence → write 3 completes, then a restart from (3C,04) with no `done` for the first sequence.
- Assert `reset_n` low mid-WAIT → all outputs 0 asynchronously. Spurious `i2c_ack` in IDLE → no state change.

Source files
------------

// File: rtl/adv7513_reg_writer.sv
// ADV7513 register-write sequencer: snapshots the requested mode on reconf and
// issues a fixed list of six register writes over a single-outstanding
// req/ack port, with per-write retry, mid-sequence restart and status flags.
module adv7513_reg_writer #(
  parameter int unsigned MAX_RETRY       = 3,
  parameter int unsigned ACK_TIMEOUT     = 4095,
  parameter bit          POWER_ON_RECONF = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       reconf,
  input  logic [5:0] vic,
  input  logic [1:0] pixel_repeat,
  input  logic [7:0] clock_delay,
  input  logic [1:0] colorspace,
  output logic       i2c_req,
  output logic [7:0] i2c_reg_addr,
  output logic [7:0] i2c_reg_data,
  input  logic       i2c_ack,
  input  logic       i2c_err,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned RetryW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  // WAIT is left on the cycle whose count reaches ACK_TIMEOUT, so that
  // i2c_req stays high for ACK_TIMEOUT+1 cycles per unanswered attempt.
  localparam logic [11:0] TmoLast = 12'(ACK_TIMEOUT - 1);
  localparam logic [2:0]  LastIdx = 3'd5;

  typedef enum logic [2:0] {StIdle, StReq, StWait, StRetry, StGap} state_e;

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [11:0]       tmo_q, tmo_d;
  logic              pending_q, pending_d;
  logic [5:0]        snap_vic_q, snap_vic_d;
  logic [1:0]        snap_pr_q, snap_pr_d;
  logic [7:0]        snap_cd_q, snap_cd_d;
  logic [1:0]        snap_cs_q, snap_cs_d;
  logic              req_q, req_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              load_snap;
  logic              restart;
  logic              cs_ycc;
  logic [7:0]        wr_addr;
  logic [7:0]        wr_data;

  assign i2c_req      = req_q;
  assign i2c_reg_addr = addr_q;
  assign i2c_reg_data = data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

  // A reconf arriving on the very cycle a pending flag is consumed counts too.
  assign restart = pending_q | reconf;
  assign cs_ycc  = snap_cs_q[1];

  // Write table: register address and data for the current index.
  always_comb begin
    wr_addr = 8'h55;
    wr_data = {1'b0, (cs_ycc ? 2'b10 : 2'b00), 5'h12};
    case (idx_q)
      3'd0: begin
        wr_addr = 8'h3C;
        wr_data = {2'b00, snap_vic_q};
      end
      3'd1: begin
        wr_addr = 8'h3B;
        wr_data = {1'b0, 2'b10, snap_pr_q, snap_pr_q, 1'b0};
      end
      3'd2: begin
        wr_addr = 8'hBA;
        wr_data = snap_cd_q;
      end
      3'd3: begin
        wr_addr = 8'h16;
        wr_data = {cs_ycc, 7'h30};
      end
      3'd4: begin
        wr_addr = 8'h18;
        wr_data = {(snap_cs_q == 2'b01), 7'h46};
      end
      default: ;
    endcase
  end

  // Sequencer next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    retry_d    = retry_q;
    tmo_d      = tmo_q;
    pending_d  = pending_q | reconf;
    snap_vic_d = snap_vic_q;
    snap_pr_d  = snap_pr_q;
    snap_cd_d  = snap_cd_q;
    snap_cs_d  = snap_cs_q;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = 1'b0;
    error_d    = error_q;
    load_snap  = 1'b0;

    case (state_q)
      StIdle: begin
        if (restart) begin
          load_snap = 1'b1;
          error_d   = 1'b0;
        end
      end
      StReq: begin
        tmo_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        tmo_d = tmo_q + 12'd1;
        if (i2c_ack && req_q && !i2c_err) begin
          state_d = StGap;
        end else if ((i2c_ack && req_q) || (tmo_q == TmoLast)) begin
          state_d = StRetry;
        end
      end
      StRetry: begin
        if (restart) begin
          load_snap = 1'b1;
        end else if (retry_q < RetryW'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          state_d = StReq;
        end else begin
          error_d = 1'b1;
          state_d = StIdle;
        end
      end
      StGap: begin
        if (restart) begin
          load_snap = 1'b1;
        end else if (idx_q == LastIdx) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          idx_d   = idx_q + 3'd1;
          retry_d = '0;
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load_snap) begin
      snap_vic_d = vic;
      snap_pr_d  = pixel_repeat;
      snap_cd_d  = clock_delay;
      snap_cs_d  = colorspace;
      idx_d      = '0;
      retry_d    = '0;
      pending_d  = 1'b0;
      state_d    = StReq;
    end

    // Outputs lag the state by one edge so every output is a plain flop.
    req_d  = (state_q == StReq) || (state_q == StWait);
    busy_d = (state_q != StIdle) && (state_d != StIdle);
    if (state_q == StReq) begin
      addr_d = wr_addr;
      data_d = wr_data;
    end
  end

  // State, snapshot and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      retry_q    <= '0;
      tmo_q      <= '0;
      pending_q  <= POWER_ON_RECONF;
      snap_vic_q <= '0;
      snap_pr_q  <= '0;
      snap_cd_q  <= '0;
      snap_cs_q  <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      tmo_q      <= tmo_d;
      pending_q  <= pending_d;
      snap_vic_q <= snap_vic_d;
      snap_pr_q  <= snap_pr_d;
      snap_cd_q  <= snap_cd_d;
      snap_cs_q  <= snap_cs_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

endmodule

// File: tb/tb_adv7513_reg_writer.sv
// Scoreboard bench for adv7513_reg_writer: expected writes are queued by the
// stimulus, a monitor pops one per rising i2c_req, a responder models the
// I2C master (zero-wait ack, scripted NACKs, or silence).
module tb_adv7513_reg_writer;

  logic       clock;
  logic       reset_n;
  logic       reconf;
  logic [5:0] vic;
  logic [1:0] pixel_repeat;
  logic [7:0] clock_delay;
  logic [1:0] colorspace;
  logic       i2c_req;
  logic [7:0] i2c_reg_addr;
  logic [7:0] i2c_reg_data;
  logic       i2c_ack;
  logic       i2c_err;
  logic       busy;
  logic       done;
  logic       error;

  adv7513_reg_writer #(
    .MAX_RETRY       (3),
    .ACK_TIMEOUT     (15),
    .POWER_ON_RECONF (1'b1)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .reconf       (reconf),
    .vic          (vic),
    .pixel_repeat (pixel_repeat),
    .clock_delay  (clock_delay),
    .colorspace   (colorspace),
    .i2c_req      (i2c_req),
    .i2c_reg_addr (i2c_reg_addr),
    .i2c_reg_data (i2c_reg_data),
    .i2c_ack      (i2c_ack),
    .i2c_err      (i2c_err),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  logic [15:0] exp_q[$];
  int          n_cmp;
  int          n_fail;
  int          done_cnt;
  int          base;
  logic        no_ack;
  logic        force_ack;
  logic [7:0]  nack_addr;
  int          nack_left;
  bit          served;
  logic        req_prev;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic push6(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                       input logic [7:0] d3, input logic [7:0] d4, input logic [7:0] d5);
    push(8'h3C, d0);
    push(8'h3B, d1);
    push(8'hBA, d2);
    push(8'h16, d3);
    push(8'h18, d4);
    push(8'h55, d5);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input logic [5:0] v, input logic [1:0] pr, input logic [7:0] cd,
                       input logic [1:0] cs);
    vic          = v;
    pixel_repeat = pr;
    clock_delay  = cd;
    colorspace   = cs;
    reconf       = 1'b1;
    step();
    reconf = 1'b0;
  endtask

  // Waits for a sequence to start (if not already) and to finish, bounded.
  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (!busy && t < 200) begin
      step();
      t++;
    end
    check({name, "_busy_rise"}, busy, 1'b1);
    t = 0;
    while (busy && t < 2000) begin
      step();
      t++;
    end
    check({name, "_busy_fall"}, busy, 1'b0);
    step();
  endtask

  // Monitor: one scoreboard pop per new request, plus done-pulse counting.
  initial begin
    logic [15:0] e;
    req_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (i2c_req && !req_prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got (%02h,%02h), expected none",
                   i2c_reg_addr, i2c_reg_data);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", {24'd0, i2c_reg_addr}, {24'd0, e[15:8]});
          check("write_data", {24'd0, i2c_reg_data}, {24'd0, e[7:0]});
        end
      end
      req_prev = i2c_req;
      if (done) done_cnt++;
    end
  end

  // I2C master model, acting 2 time units after each rising edge.
  initial begin
    i2c_ack = 1'b0;
    i2c_err = 1'b0;
    served  = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      i2c_ack = 1'b0;
      i2c_err = 1'b0;
      if (force_ack) begin
        i2c_ack = 1'b1;
      end else if (!i2c_req) begin
        served = 1'b0;
      end else if (!served && !no_ack) begin
        served  = 1'b1;
        i2c_ack = 1'b1;
        if (nack_left > 0 && i2c_reg_addr == nack_addr) begin
          i2c_err = 1'b1;
          nack_left--;
        end
      end
    end
  end

  initial begin
    int t;
    int cnt;
    n_cmp        = 0;
    n_fail       = 0;
    done_cnt     = 0;
    reset_n      = 1'b0;
    reconf       = 1'b0;
    vic          = 6'd16;
    pixel_repeat = 2'd0;
    clock_delay  = 8'h60;
    colorspace   = 2'b00;
    no_ack       = 1'b0;
    force_ack    = 1'b0;
    nack_addr    = 8'h00;
    nack_left    = 0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_req", i2c_req, 1'b0);
    check("rst_addr", i2c_reg_addr, 8'h00);
    check("rst_data", i2c_reg_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);

    // Power-on sequence without any reconf.
    push6(8'h10, 8'h40, 8'h60, 8'h30, 8'h46, 8'h12);
    base    = done_cnt;
    reset_n = 1'b1;
    wait_idle("power_on");
    check("power_on_done", done_cnt - base, 1);
    check("power_on_error", error, 1'b0);

    // RGB limited, with reconf-to-request latency checks.
    push6(8'h04, 8'h40, 8'h25, 8'h30, 8'hC6, 8'h12);
    base         = done_cnt;
    vic          = 6'd4;
    pixel_repeat = 2'd0;
    clock_delay  = 8'h25;
    colorspace   = 2'b01;
    reconf       = 1'b1;
    step();
    reconf = 1'b0;
    check("lat_busy_k", busy, 1'b0);
    check("lat_req_k", i2c_req, 1'b0);
    step();
    check("lat_busy_k1", busy, 1'b1);
    check("lat_req_k1", i2c_req, 1'b1);
    check("lat_addr_k1", i2c_reg_addr, 8'h3C);
    wait_idle("cs01");
    check("cs01_done", done_cnt - base, 1);

    // YCbCr 4:4:4 with pixel repetition 1.
    push6(8'h1F, 8'h4A, 8'hA5, 8'hB0, 8'h46, 8'h52);
    base = done_cnt;
    start(6'd31, 2'd1, 8'hA5, 2'b10);
    wait_idle("cs10");
    check("cs10_done", done_cnt - base, 1);

    // Reserved colorspace behaves as YCbCr; pixel repetition 2.
    push6(8'h10, 8'h54, 8'h0F, 8'hB0, 8'h46, 8'h52);
    base = done_cnt;
    start(6'd16, 2'd2, 8'h0F, 2'b11);
    wait_idle("cs11");
    check("cs11_done", done_cnt - base, 1);

    // Two NACKs on 0xBA, then success.
    nack_addr = 8'hBA;
    nack_left = 2;
    push(8'h3C, 8'h10);
    push(8'h3B, 8'h40);
    push(8'hBA, 8'h60);
    push(8'hBA, 8'h60);
    push(8'hBA, 8'h60);
    push(8'h16, 8'h30);
    push(8'h18, 8'h46);
    push(8'h55, 8'h12);
    base = done_cnt;
    start(6'd16, 2'd0, 8'h60, 2'b00);
    wait_idle("nack2");
    check("nack2_done", done_cnt - base, 1);
    check("nack2_error", error, 1'b0);
    check("nack2_used", nack_left, 0);

    // Permanent NACK: four attempts then abort.
    nack_addr = 8'h3C;
    nack_left = 1000;
    repeat (4) push(8'h3C, 8'h10);
    base = done_cnt;
    start(6'd16, 2'd0, 8'h60, 2'b00);
    wait_idle("nack_perm");
    check("nack_perm_done", done_cnt - base, 0);
    check("nack_perm_error", error, 1'b1);
    nack_left = 0;

    // Silent master: each attempt holds i2c_req for ACK_TIMEOUT+1 = 16 cycles.
    no_ack = 1'b1;
    repeat (4) push(8'h3C, 8'h10);
    base = done_cnt;
    start(6'd16, 2'd0, 8'h60, 2'b00);
    for (int a = 0; a < 4; a++) begin
      t = 0;
      while (!i2c_req && t < 50) begin
        step();
        t++;
      end
      cnt = 0;
      while (i2c_req && cnt < 100) begin
        cnt++;
        step();
      end
      check("timeout_req_high", cnt, 16);
    end
    step();
    check("timeout_error", error, 1'b1);
    check("timeout_busy", busy, 1'b0);
    check("timeout_done", done_cnt - base, 0);
    no_ack = 1'b0;

    // Spurious ack while idle: nothing changes.
    force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    repeat (3) step();
    check("spur_busy", busy, 1'b0);
    check("spur_req", i2c_req, 1'b0);
    check("spur_error", error, 1'b1);

    // Restart during write 3, coincident with its ack.
    push(8'h3C, 8'h10);
    push(8'h3B, 8'h40);
    push(8'hBA, 8'h60);
    push(8'h16, 8'h30);
    push6(8'h04, 8'h40, 8'h60, 8'h30, 8'h46, 8'h12);
    base = done_cnt;
    start(6'd16, 2'd0, 8'h60, 2'b00);
    t = 0;
    while (!(i2c_req && i2c_reg_addr == 8'h16) && t < 100) begin
      step();
      t++;
    end
    check("restart_reach_w3", i2c_reg_addr, 8'h16);
    vic    = 6'd4;
    reconf = 1'b1;
    step();
    reconf = 1'b0;
    wait_idle("restart");
    check("restart_done", done_cnt - base, 1);
    check("restart_error", error, 1'b0);

    // Asynchronous reset while waiting for an ack.
    no_ack = 1'b1;
    push(8'h3C, 8'h10);
    start(6'd16, 2'd0, 8'h60, 2'b00);
    t = 0;
    while (!i2c_req && t < 50) begin
      step();
      t++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_req", i2c_req, 1'b0);
    check("async_rst_addr", i2c_reg_addr, 8'h00);
    check("async_rst_data", i2c_reg_data, 8'h00);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_done", done, 1'b0);
    check("async_rst_error", error, 1'b0);
    exp_q.delete();
    no_ack = 1'b0;
    push6(8'h10, 8'h40, 8'h60, 8'h30, 8'h46, 8'h12);
    base = done_cnt;
    step();
    reset_n = 1'b1;
    wait_idle("post_reset");
    check("post_reset_done", done_cnt - base, 1);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
